alu_sequencer: RTL and testbench

Issue controller for the 16-bit ALU slice datapath. It accepts one operation at a time over a valid/ready request channel and decodes it into the ALU's one-hot control lines. It drives operands, captures `ALUOut` and the flag outputs, maintains the architectural C/Z/N flags and returns the result over a valid/ready response channel. It sits between the core's execute stage and the ALU instance.

---
 rtl/alu_seq_pkg.sv | 74 +++++++
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_seq_decode.sv | 72 +++++++
 rtl/alu_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the ALU issue sequencer.
//   alu_op_e        - 4-bit request opcode
//   alu_seq_state_e - sequencer FSM states
//   alu_ctrl_t      - packed bundle of every ALU control line
// Build option: ALU_SEQ_DWORD_EN adds the high-half execute state.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpAdc  = 4'd1,
        OpSub  = 4'd2,
        OpSbc  = 4'd3,
        OpNeg  = 4'd4,
        OpAnd  = 4'd5,
        OpOr   = 4'd6,
        OpXor  = 4'd7,
        OpNot  = 4'd8,
        OpNand = 4'd9,
        OpNor  = 4'd10,
        OpShl  = 4'd11,
        OpShr  = 4'd12,
        OpAsr  = 4'd13,
        OpLui  = 4'd14,
        OpLli  = 4'd15
    } alu_op_e;

    // Highest opcode that may be chained over two halves.
    localparam alu_op_e LastDwordOp = OpSbc;
    // Highest opcode that updates the carry flag.
    localparam alu_op_e LastArithOp = OpNeg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StExec   = 2'd1,
        StResp   = 2'd2
`ifdef ALU_SEQ_DWORD_EN
        ,
        StExecHi = 2'd3
`endif
    } alu_seq_state_e;

    typedef struct packed {
        logic cin;
        logic sub;
        logic zero_a;
        logic fa_out;
        logic and_op;
        logic or_op;
        logic xor_op;
        logic not_op;
        logic nand_op;
        logic nor_op;
        logic sign;
        logic sh_sign_in;
        logic sh1;
        logic sh2;
        logic sh4;
        logic sh8;
        logic sh_b;
        logic sh_l;
        logic sh_r;
        logic sh_out;
        logic lli;
    } alu_ctrl_t;

    function automatic logic is_arith(input alu_op_e op);
        return op <= LastArithOp;
    endfunction

    function automatic logic dword_capable(input alu_op_e op);
        return op <= LastDwordOp;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response channel between the execute stage (master)
// and the ALU sequencer (slave), plus the architectural flags.
//   Req*  - valid/ready request: opcode, shift amount, dword, 32-bit operands
//   Rsp*  - valid/ready response: 32-bit data and illegal-request error
//   Flag* - architectural C/Z/N flags
interface alu_seq_if;
    logic        ReqValid;
    logic        ReqReady;
    logic [3:0]  ReqOp;
    logic [3:0]  ReqShAmt;
    logic        ReqDword;
    logic [31:0] ReqA;
    logic [31:0] ReqB;
    logic        RspValid;
    logic        RspReady;
    logic [31:0] RspData;
    logic        RspErr;
    logic        FlagC;
    logic        FlagZ;
    logic        FlagN;

    modport master (
        output ReqValid, ReqOp, ReqShAmt, ReqDword, ReqA, ReqB, RspReady,
        input  ReqReady, RspValid, RspData, RspErr, FlagC, FlagZ, FlagN
    );

    modport slave (
        input  ReqValid, ReqOp, ReqShAmt, ReqDword, ReqA, ReqB, RspReady,
        output ReqReady, RspValid, RspData, RspErr, FlagC, FlagZ, FlagN
    );
endinterface

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: combinational opcode decoder.
//   op, sh_amt - latched opcode and shift amount
//   flag_c     - architectural carry, feeds CIn for ADC/SBC
//   a_msb      - operand A sign bit, shifted in by ASR
//   ctrl       - ALU control lines
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  alu_op_e    op,
    input  logic [3:0] sh_amt,
    input  logic       flag_c,
    input  logic       a_msb,
    output alu_ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (op)
            OpAdd: begin
                ctrl.fa_out = 1'b1;
            end
            OpAdc: begin
                ctrl.fa_out = 1'b1;
                ctrl.cin    = flag_c;
            end
            OpSub: begin
                ctrl.fa_out = 1'b1;
                ctrl.sub    = 1'b1;
                ctrl.cin    = 1'b1;
            end
            OpSbc: begin
                ctrl.fa_out = 1'b1;
                ctrl.sub    = 1'b1;
                ctrl.cin    = flag_c;
            end
            OpNeg: begin
                ctrl.fa_out = 1'b1;
                ctrl.sub    = 1'b1;
                ctrl.zero_a = 1'b1;
                ctrl.cin    = 1'b1;
            end
            OpAnd:  ctrl.and_op  = 1'b1;
            OpOr:   ctrl.or_op   = 1'b1;
            OpXor:  ctrl.xor_op  = 1'b1;
            OpNot:  ctrl.not_op  = 1'b1;
            OpNand: ctrl.nand_op = 1'b1;
            OpNor:  ctrl.nor_op  = 1'b1;
            OpShl, OpShr, OpAsr: begin
                ctrl.sh_out     = 1'b1;
                ctrl.sh_l       = (op == OpShl);
                ctrl.sh_r       = (op != OpShl);
                ctrl.sh_sign_in = (op == OpAsr) & a_msb;
                ctrl.sh1        = sh_amt[0];
                ctrl.sh2        = sh_amt[1];
                ctrl.sh4        = sh_amt[2];
                ctrl.sh8        = sh_amt[3];
            end
            OpLui: begin
                // B shifted left by 8 through the shifter
                ctrl.sh_out = 1'b1;
                ctrl.sh_b   = 1'b1;
                ctrl.sh_l   = 1'b1;
                ctrl.sh8    = 1'b1;
            end
            OpLli: begin
                ctrl.sh_out = 1'b1;
                ctrl.lli    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issue controller for the 16-bit ALU slice.
// Accepts one op over bus (alu_seq_if.slave), drives the ALU for one cycle
// (two for dword), captures the result and flags, and returns a response.
//   Clock, Reset        - clock; asynchronous active-high reset
//   bus                 - request/response channel and C/Z/N flags
//   A, B                - ALU operands (zero outside execute)
//   CIn .. LLI          - ALU control lines (zero outside execute)
//   ALUEnable           - high during execute cycles
//   ALUOut, COut, nZ, Sum - ALU result and flag outputs
// Build option: ALU_SEQ_DWORD_EN enables 32-bit chained arithmetic (ops 0-3).
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    alu_seq_if.slave     bus,
    output logic [W-1:0] A,
    output logic [W-1:0] B,
    output logic         CIn,
    output logic         SUB,
    output logic         ZeroA,
    output logic         FAOut,
    output logic         AND,
    output logic         OR,
    output logic         XOR,
    output logic         NOT,
    output logic         NAND,
    output logic         NOR,
    output logic         Sign,
    output logic         ShSignIn,
    output logic         Sh1,
    output logic         Sh2,
    output logic         Sh4,
    output logic         Sh8,
    output logic         ShB,
    output logic         ShL,
    output logic         ShR,
    output logic         ShOut,
    output logic         LLI,
    output logic         ALUEnable,
    input  logic [W-1:0] ALUOut,
    input  logic         COut,
    input  logic         nZ,
    input  logic         Sum
);

`ifdef ALU_SEQ_DWORD_EN
    localparam int unsigned OpW = 2 * W;
`else
    localparam int unsigned OpW = W;
`endif

    alu_seq_state_e state_q, state_d;
    alu_op_e        op_q, op_d;
    logic [3:0]     sh_amt_q, sh_amt_d;
    logic [OpW-1:0] a_q, a_d, b_q, b_d;
    logic [OpW-1:0] rsp_data_q, rsp_data_d;
    logic           rsp_err_q, rsp_err_d;
    logic           flag_c_q, flag_c_d;
    logic           flag_z_q, flag_z_d;
    logic           flag_n_q, flag_n_d;
`ifdef ALU_SEQ_DWORD_EN
    logic           dword_q, dword_d;
    logic           cout_lo_q, cout_lo_d;
    logic           zero_lo_q, zero_lo_d;
`endif
    logic           illegal;
    logic           alu_en;
    alu_ctrl_t      dec_ctrl, ctrl;

    alu_seq_decode u_decode (
        .op     (op_q),
        .sh_amt (sh_amt_q),
        .flag_c (flag_c_q),
        .a_msb  (a_q[W-1]),
        .ctrl   (dec_ctrl)
    );

    always_comb begin
`ifdef ALU_SEQ_DWORD_EN
        illegal = bus.ReqDword && !dword_capable(alu_op_e'(bus.ReqOp));
`else
        illegal = bus.ReqDword;
`endif
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sh_amt_d   = sh_amt_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        flag_c_d   = flag_c_q;
        flag_z_d   = flag_z_q;
        flag_n_d   = flag_n_q;
`ifdef ALU_SEQ_DWORD_EN
        dword_d    = dword_q;
        cout_lo_d  = cout_lo_q;
        zero_lo_d  = zero_lo_q;
`endif
        alu_en     = 1'b0;
        ctrl       = '0;
        A          = '0;
        B          = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.ReqValid) begin
                    if (illegal) begin
                        // Straight to response, ALU and flags untouched
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        state_d    = StResp;
                    end else begin
                        op_d      = alu_op_e'(bus.ReqOp);
                        sh_amt_d  = bus.ReqShAmt;
                        a_d       = bus.ReqA[OpW-1:0];
                        b_d       = bus.ReqB[OpW-1:0];
                        rsp_err_d = 1'b0;
`ifdef ALU_SEQ_DWORD_EN
                        dword_d   = bus.ReqDword;
`endif
                        state_d   = StExec;
                    end
                end
            end
            StExec: begin
                alu_en                = 1'b1;
                ctrl                  = dec_ctrl;
                A                     = a_q[W-1:0];
                B                     = b_q[W-1:0];
                rsp_data_d            = '0;
                rsp_data_d[W-1:0]     = ALUOut;
                if (is_arith(op_q)) begin
                    flag_c_d = COut;
                end
                flag_z_d = ~nZ;
                flag_n_d = Sum;
                state_d  = StResp;
`ifdef ALU_SEQ_DWORD_EN
                if (dword_q) begin
                    // Flags come from the combined result; only stash the low half here
                    flag_c_d  = flag_c_q;
                    flag_z_d  = flag_z_q;
                    flag_n_d  = flag_n_q;
                    cout_lo_d = COut;
                    zero_lo_d = ~nZ;
                    state_d   = StExecHi;
                end
`endif
            end
`ifdef ALU_SEQ_DWORD_EN
            StExecHi: begin
                alu_en                = 1'b1;
                ctrl                  = dec_ctrl;
                ctrl.cin              = cout_lo_q;
                A                     = a_q[OpW-1:W];
                B                     = b_q[OpW-1:W];
                rsp_data_d[OpW-1:W]   = ALUOut;
                flag_c_d              = COut;
                flag_z_d              = zero_lo_q & ~nZ;
                flag_n_d              = Sum;
                state_d               = StResp;
            end
`endif
            StResp: begin
                if (bus.RspReady) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= StIdle;
            op_q       <= OpAdd;
            sh_amt_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            flag_c_q   <= 1'b0;
            flag_z_q   <= 1'b0;
            flag_n_q   <= 1'b0;
`ifdef ALU_SEQ_DWORD_EN
            dword_q    <= 1'b0;
            cout_lo_q  <= 1'b0;
            zero_lo_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            sh_amt_q   <= sh_amt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            flag_c_q   <= flag_c_d;
            flag_z_q   <= flag_z_d;
            flag_n_q   <= flag_n_d;
`ifdef ALU_SEQ_DWORD_EN
            dword_q    <= dword_d;
            cout_lo_q  <= cout_lo_d;
            zero_lo_q  <= zero_lo_d;
`endif
        end
    end

    assign bus.ReqReady = (state_q == StIdle);
    assign bus.RspValid = (state_q == StResp);
    assign bus.RspErr   = rsp_err_q;
    assign bus.FlagC    = flag_c_q;
    assign bus.FlagZ    = flag_z_q;
    assign bus.FlagN    = flag_n_q;
`ifdef ALU_SEQ_DWORD_EN
    assign bus.RspData  = rsp_data_q;
`else
    assign bus.RspData  = {{W{1'b0}}, rsp_data_q};
`endif

    assign ALUEnable = alu_en;
    assign CIn       = ctrl.cin;
    assign SUB       = ctrl.sub;
    assign ZeroA     = ctrl.zero_a;
    assign FAOut     = ctrl.fa_out;
    assign AND       = ctrl.and_op;
    assign OR        = ctrl.or_op;
    assign XOR       = ctrl.xor_op;
    assign NOT       = ctrl.not_op;
    assign NAND      = ctrl.nand_op;
    assign NOR       = ctrl.nor_op;
    assign Sign      = ctrl.sign;
    assign ShSignIn  = ctrl.sh_sign_in;
    assign Sh1       = ctrl.sh1;
    assign Sh2       = ctrl.sh2;
    assign Sh4       = ctrl.sh4;
    assign Sh8       = ctrl.sh8;
    assign ShB       = ctrl.sh_b;
    assign ShL       = ctrl.sh_l;
    assign ShR       = ctrl.sh_r;
    assign ShOut     = ctrl.sh_out;
    assign LLI       = ctrl.lli;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: self-checking bench for alu_sequencer with a behavioural
// model of the 16-bit ALU slice. Honours ALU_SEQ_DWORD_EN when defined.
module tb_alu_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] A, B, ALUOut;
    logic        CIn, SUB, ZeroA, FAOut, AND, OR, XOR, NOT, NAND, NOR, Sign;
    logic        ShSignIn, Sh1, Sh2, Sh4, Sh8, ShB, ShL, ShR, ShOut, LLI, ALUEnable;
    logic        COut, nZ, Sum;
    logic [20:0] ctrl_lines;

    int checks = 0;
    int errors = 0;

    alu_seq_if bus ();

    alu_sequencer #(.W(16)) dut (
        .Clock(Clock), .Reset(Reset), .bus(bus),
        .A(A), .B(B), .CIn(CIn), .SUB(SUB), .ZeroA(ZeroA), .FAOut(FAOut),
        .AND(AND), .OR(OR), .XOR(XOR), .NOT(NOT), .NAND(NAND), .NOR(NOR),
        .Sign(Sign), .ShSignIn(ShSignIn), .Sh1(Sh1), .Sh2(Sh2), .Sh4(Sh4),
        .Sh8(Sh8), .ShB(ShB), .ShL(ShL), .ShR(ShR), .ShOut(ShOut), .LLI(LLI),
        .ALUEnable(ALUEnable), .ALUOut(ALUOut), .COut(COut), .nZ(nZ), .Sum(Sum)
    );

    always #5 Clock = ~Clock;

    assign ctrl_lines = {CIn, SUB, ZeroA, FAOut, AND, OR, XOR, NOT, NAND, NOR, Sign,
                         ShSignIn, Sh1, Sh2, Sh4, Sh8, ShB, ShL, ShR, ShOut, LLI};

    // Behavioural ALU slice
    logic [16:0] fa;
    logic [15:0] sh_src;
    logic [3:0]  amt;
    logic [31:0] ext;
    always_comb begin
        fa     = {1'b0, (ZeroA ? 16'h0 : A)} + {1'b0, (SUB ? ~B : B)} + {16'h0, CIn};
        amt    = {Sh8, Sh4, Sh2, Sh1};
        sh_src = ShB ? B : A;
        ext    = {{16{ShSignIn}}, sh_src};
        ALUOut = 16'h0;
        COut   = 1'b0;
        if (FAOut) begin
            ALUOut = fa[15:0];
            COut   = fa[16];
        end else if (AND)  ALUOut = A & B;
        else if (OR)   ALUOut = A | B;
        else if (XOR)  ALUOut = A ^ B;
        else if (NOT)  ALUOut = ~A;
        else if (NAND) ALUOut = ~(A & B);
        else if (NOR)  ALUOut = ~(A | B);
        else if (ShOut) begin
            if (LLI)      ALUOut = {A[15:8], B[7:0]};
            else if (ShL) ALUOut = sh_src << amt;
            else if (ShR) ALUOut = 16'(ext >> amt);
        end
        nZ  = |ALUOut;
        Sum = ALUOut[15];
    end

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  sh;
        logic        dw;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        err;
        logic        c;
        logic        z;
        logic        n;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [3:0] sh, input logic dw,
                        input logic [31:0] a, input logic [31:0] b);
        @(negedge Clock);
        bus.ReqOp    = op;
        bus.ReqShAmt = sh;
        bus.ReqDword = dw;
        bus.ReqA     = a;
        bus.ReqB     = b;
        bus.ReqValid = 1'b1;
        check("req_ready_before_accept", bus.ReqReady, 1);
        @(posedge Clock);
        #1 bus.ReqValid = 1'b0;
    endtask

    // Counts falling edges from acceptance until RspValid is seen
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(negedge Clock);
            lat++;
            if (bus.RspValid) break;
        end
        check("rsp_valid_within_bound", bus.RspValid, 1);
    endtask

    task automatic finish_rsp();
        bus.RspReady = 1'b1;
        @(posedge Clock);
        #1 bus.RspReady = 1'b0;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int lat;
        send(v.op, v.sh, v.dw, v.a, v.b);
        wait_rsp(lat);
        check({name, " latency"}, lat, v.err ? 1 : (v.dw ? 3 : 2));
        check({name, " data"}, bus.RspData, v.data);
        check({name, " err"}, bus.RspErr, v.err);
        check({name, " flags"}, {bus.FlagC, bus.FlagZ, bus.FlagN}, {v.c, v.z, v.n});
        check({name, " alu_idle_in_resp"}, {ALUEnable, A, B, ctrl_lines}, 0);
        check({name, " req_ready_in_resp"}, bus.ReqReady, 0);
        finish_rsp();
    endtask

    initial begin
        int   lat;
        logic [31:0] held_data;
        logic [2:0]  held_flags;

        bus.ReqValid = 1'b0;
        bus.ReqOp    = '0;
        bus.ReqShAmt = '0;
        bus.ReqDword = 1'b0;
        bus.ReqA     = '0;
        bus.ReqB     = '0;
        bus.RspReady = 1'b0;

        //            op     sh     dw    a             b             data          err c z n
        vecs[0]  = '{4'd0,  4'd0,  1'b0, 32'd16328,    32'd9000,     32'd25328,    0, 0, 0, 0};
        vecs[1]  = '{4'd2,  4'd0,  1'b0, 32'd16328,    32'd9000,     32'd7328,     0, 1, 0, 0};
        vecs[2]  = '{4'd15, 4'd0,  1'b0, 32'h3FC8,     32'h0043,     32'h3F43,     0, 1, 0, 0};
        vecs[3]  = '{4'd11, 4'd1,  1'b0, 32'd16328,    32'd0,        32'd32656,    0, 1, 0, 0};
        vecs[4]  = '{4'd13, 4'd15, 1'b0, 32'hFFE9,     32'd0,        32'hFFFF,     0, 1, 0, 1};
        vecs[5]  = '{4'd4,  4'd0,  1'b0, 32'd16328,    32'd9000,     32'd56536,    0, 0, 0, 1};
        vecs[6]  = '{4'd2,  4'd0,  1'b0, 32'd5,        32'd5,        32'd0,        0, 1, 1, 0};
        vecs[7]  = '{4'd1,  4'd0,  1'b0, 32'd1,        32'd2,        32'd4,        0, 0, 0, 0};
        vecs[8]  = '{4'd3,  4'd0,  1'b0, 32'd5,        32'd3,        32'd1,        0, 1, 0, 0};
        vecs[9]  = '{4'd5,  4'd0,  1'b0, 32'h00F0,     32'h0F0F,     32'h0000,     0, 1, 1, 0};
        vecs[10] = '{4'd6,  4'd0,  1'b0, 32'h8000,     32'h0001,     32'h8001,     0, 1, 0, 1};
        vecs[11] = '{4'd7,  4'd0,  1'b0, 32'hFFFF,     32'hFFFF,     32'h0000,     0, 1, 1, 0};
        vecs[12] = '{4'd8,  4'd0,  1'b0, 32'h00FF,     32'h0000,     32'hFF00,     0, 1, 0, 1};
        vecs[13] = '{4'd9,  4'd0,  1'b0, 32'hFFFF,     32'hFFFF,     32'h0000,     0, 1, 1, 0};
        vecs[14] = '{4'd10, 4'd0,  1'b0, 32'h0000,     32'h0000,     32'hFFFF,     0, 1, 0, 1};
        vecs[15] = '{4'd12, 4'd4,  1'b0, 32'h8000,     32'h0000,     32'h0800,     0, 1, 0, 0};
        vecs[16] = '{4'd14, 4'd0,  1'b0, 32'h1234,     32'h00AB,     32'hAB00,     0, 1, 0, 1};
        vecs[17] = '{4'd5,  4'd0,  1'b1, 32'h000F,     32'h000F,     32'h0000,     1, 1, 0, 1};
`ifdef ALU_SEQ_DWORD_EN
        vecs[18] = '{4'd0,  4'd0,  1'b1, 32'h0000FFFF, 32'h00000001, 32'h00010000, 0, 0, 0, 0};
`else
        vecs[18] = '{4'd0,  4'd0,  1'b1, 32'h0000FFFF, 32'h00000001, 32'h00000000, 1, 1, 0, 1};
`endif

        // Reset values, during and after reset
        #3;
        check("reset ready", bus.ReqReady, 1);
        check("reset rsp", {bus.RspValid, bus.RspErr, bus.RspData}, 0);
        check("reset flags", {bus.FlagC, bus.FlagZ, bus.FlagN}, 0);
        check("reset alu", {ALUEnable, A, B, ctrl_lines}, 0);
        #9 Reset = 1'b0;
        @(negedge Clock);
        check("post reset idle", {bus.ReqReady, bus.RspValid}, 2'b10);

        for (int i = 0; i < NV; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

`ifdef ALU_SEQ_DWORD_EN
        // Dword carry chaining seen on the ALU side
        send(4'd0, 4'd0, 1'b1, 32'h0000FFFF, 32'h00000001);
        @(negedge Clock);
        check("dw lo", {ALUEnable, CIn, FAOut, A, B}, {1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0001});
        @(negedge Clock);
        check("dw hi", {ALUEnable, CIn, FAOut, A, B}, {1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000});
        @(negedge Clock);
        check("dw rsp", {bus.RspValid, bus.RspData}, {1'b1, 32'h00010000});
        finish_rsp();
`endif

        // Response stall with a competing request
        send(4'd0, 4'd0, 1'b0, 32'd100, 32'd23);
        wait_rsp(lat);
        held_data  = bus.RspData;
        held_flags = {bus.FlagC, bus.FlagZ, bus.FlagN};
        check("stall data", held_data, 123);
        bus.ReqOp    = 4'd2;
        bus.ReqShAmt = 4'd0;
        bus.ReqDword = 1'b0;
        bus.ReqA     = 32'd200;
        bus.ReqB     = 32'd50;
        bus.ReqValid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clock);
            check($sformatf("stall%0d hold", k),
                  {bus.RspValid, bus.ReqReady, bus.RspErr, bus.RspData,
                   bus.FlagC, bus.FlagZ, bus.FlagN},
                  {2'b10, 1'b0, held_data, held_flags});
        end
        finish_rsp();
        @(negedge Clock);
        check("after handshake idle", {bus.RspValid, bus.ReqReady}, 2'b01);
        @(posedge Clock);
        #1 bus.ReqValid = 1'b0;
        check("second accepted", bus.ReqReady, 0);
        wait_rsp(lat);
        check("second latency", lat, 2);
        check("second data", bus.RspData, 150);
        check("second flags", {bus.FlagC, bus.FlagZ, bus.FlagN}, 3'b100);
        finish_rsp();

        // Reset during EXEC drops the request
        send(4'd0, 4'd0, 1'b0, 32'd1, 32'd2);
        @(negedge Clock);
        check("in exec", {ALUEnable, FAOut}, 2'b11);
        #2 Reset = 1'b1;
        #1;
        check("async reset alu", {ALUEnable, A, B, ctrl_lines}, 0);
        check("async reset chan", {bus.ReqReady, bus.RspValid, bus.RspErr, bus.RspData}, {1'b1, 34'h0});
        check("async reset flags", {bus.FlagC, bus.FlagZ, bus.FlagN}, 0);
        @(negedge Clock);
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clock);
            check($sformatf("no rsp after reset %0d", k), {bus.RspValid, bus.ReqReady}, 2'b01);
        end
        run_vec("post reset add", '{4'd0, 4'd0, 1'b0, 32'd7, 32'd8, 32'd15, 0, 0, 0, 0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
